// File: rtl/gate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq_ctrl
// Purpose  : Gate-time sequencer for a frequency counter with auto-ranging.
//            It runs a continuous CLEAR -> GATE -> HOLD -> DECIDE cycle.
//            At the end of each window it either loads the display latch or
//            throws the window away and switches range.
// Ports    : sysclk, reset          - clock, synchronous active-high reset
//            auto_en, man_high      - range mode / manual range select
//            ovf, bcd_th, bcd_hun   - status of the external BCD counter
//            cnt_clr, cnt_en        - counter clear pulse / gate enable
//            latch_en, meas_valid   - display load pulse / result strobe
//            highfreq               - active range (prescaler mux, DP)
//            range_chg              - window discarded due to range switch
//            ovf_flag               - over-range flag of displayed value
// Revision : 1.0 - initial release
// ============================================================================
module gate_seq_ctrl #(
    parameter int GATE_CYCLES   = 100000000,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       auto_en,
    input  logic       man_high,
    input  logic       ovf,
    input  logic [3:0] bcd_th,
    input  logic [3:0] bcd_hun,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       latch_en,
    output logic       highfreq,
    output logic       meas_valid,
    output logic       range_chg,
    output logic       ovf_flag
);

    // state_q names the phase whose outputs are loaded on the next edge.
    // The output registers therefore trail it by one cycle. This lets the
    // first cycle after reset already show cnt_clr=1 while every output
    // stays a flop.
    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_DECIDE = 2'd3;

    localparam int GCW = 27;
    localparam int SCW = 8;

    logic [1:0]     state_q,    state_d;
    logic [GCW-1:0] gate_cnt_q, gate_cnt_d;
    logic [SCW-1:0] set_cnt_q,  set_cnt_d;
    logic           clr_q,      clr_d;
    logic           en_q,       en_d;
    logic           latch_q,    latch_d;
    logic           mv_q,       mv_d;
    logic           rchg_q,     rchg_d;
    logic           ovff_q,     ovff_d;
    logic           hf_q,       hf_d;
    // The decided range is parked here.
    // It is applied only on the DECIDE-to-CLEAR edge.
    logic           hf_next_q,  hf_next_d;
    logic           w_under;

    // High-range window counted below 100: the thousands and hundreds digits
    // are both zero and the counter did not wrap.
    assign w_under = !ovf && (bcd_th == 4'd0) && (bcd_hun == 4'd0);

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        set_cnt_d  = set_cnt_q;
        clr_d      = 1'b0;
        en_d       = 1'b0;
        latch_d    = 1'b0;
        mv_d       = 1'b0;
        rchg_d     = 1'b0;
        ovff_d     = ovff_q;
        hf_d       = hf_q;
        hf_next_d  = hf_next_q;

        case (state_q)
            ST_CLEAR: begin
                clr_d      = 1'b1;
                hf_d       = hf_next_q;
                gate_cnt_d = GCW'(GATE_CYCLES - 1);
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                en_d = 1'b1;
                if (gate_cnt_q == '0) begin
                    set_cnt_d = SCW'(SETTLE_CYCLES - 1);
                    state_d   = ST_HOLD;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (set_cnt_q == '0) begin
                    state_d = ST_DECIDE;
                end else begin
                    set_cnt_d = set_cnt_q - 1'b1;
                end
            end
            default: begin // ST_DECIDE
                state_d = ST_CLEAR;
                if (auto_en && !hf_q && ovf) begin
                    rchg_d    = 1'b1;
                    hf_next_d = 1'b1;
                end else if (auto_en && hf_q && w_under) begin
                    rchg_d    = 1'b1;
                    hf_next_d = 1'b0;
                end else begin
                    // This branch also covers high range with ovf=1, since
                    // there is no higher range to switch to.
                    latch_d   = 1'b1;
                    mv_d      = 1'b1;
                    ovff_d    = ovf;
                    hf_next_d = auto_en ? hf_q : man_high;
                end
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            gate_cnt_q <= '0;
            set_cnt_q  <= '0;
            clr_q      <= 1'b0;
            en_q       <= 1'b0;
            latch_q    <= 1'b0;
            mv_q       <= 1'b0;
            rchg_q     <= 1'b0;
            ovff_q     <= 1'b0;
            hf_q       <= 1'b0;
            hf_next_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            set_cnt_q  <= set_cnt_d;
            clr_q      <= clr_d;
            en_q       <= en_d;
            latch_q    <= latch_d;
            mv_q       <= mv_d;
            rchg_q     <= rchg_d;
            ovff_q     <= ovff_d;
            hf_q       <= hf_d;
            hf_next_q  <= hf_next_d;
        end
    end

    assign cnt_clr    = clr_q;
    assign cnt_en     = en_q;
    assign latch_en   = latch_q;
    assign meas_valid = mv_q;
    assign range_chg  = rchg_q;
    assign ovf_flag   = ovff_q;
    assign highfreq   = hf_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_seq_ctrl
// Purpose  : Directed self-checking bench for gate_seq_ctrl with
//            GATE_CYCLES=10 and SETTLE_CYCLES=2, giving a 14-cycle period.
//            Cycle 0 is CLEAR, cycles 1-10 are GATE, 11-12 are HOLD and
//            cycle 13 is DECIDE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_seq_ctrl;

    logic       sysclk;
    logic       reset;
    logic       auto_en;
    logic       man_high;
    logic       ovf;
    logic [3:0] bcd_th;
    logic [3:0] bcd_hun;
    logic       cnt_clr;
    logic       cnt_en;
    logic       latch_en;
    logic       highfreq;
    logic       meas_valid;
    logic       range_chg;
    logic       ovf_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered over one window by run_window
    int   obs_clr_n, obs_en_n, obs_en_first, obs_en_last;
    int   obs_latch_n, obs_latch_cyc, obs_mv_n, obs_rchg_n, obs_rchg_cyc;
    logic obs_hf0, obs_hf_stable, obs_next_clr, obs_hf_next, obs_ovf_flag;

    gate_seq_ctrl #(
        .GATE_CYCLES   (10),
        .SETTLE_CYCLES (2)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .auto_en    (auto_en),
        .man_high   (man_high),
        .ovf        (ovf),
        .bcd_th     (bcd_th),
        .bcd_hun    (bcd_hun),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .latch_en   (latch_en),
        .highfreq   (highfreq),
        .meas_valid (meas_valid),
        .range_chg  (range_chg),
        .ovf_flag   (ovf_flag)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Checks on every cycle: the three sequencing strobes never overlap, and
    // meas_valid always coincides with latch_en.
    always @(negedge sysclk) begin
        n_checks++;
        if (((cnt_clr & cnt_en) | (cnt_clr & latch_en) | (cnt_en & latch_en)
             | (meas_valid ^ latch_en) | (range_chg & latch_en)) === 1'b1) begin
            n_fail++;
            $display("FAIL exclusivity @%0t: clr=%b en=%b latch=%b mv=%b rchg=%b, required one-hot strobes",
                     $time, cnt_clr, cnt_en, latch_en, meas_valid, range_chg);
        end
    end

    // Entered at the negedge of cycle 0 (CLEAR). It applies the counter status
    // for this window and records 14 cycles of activity. It returns at the
    // negedge of the next cycle 0. man_high is toggled at cycle mh_cyc
    // (-1 = never).
    task automatic run_window(input logic ovf_v, input logic [3:0] th_v,
                              input logic [3:0] hun_v, input int mh_cyc);
        ovf = ovf_v; bcd_th = th_v; bcd_hun = hun_v;
        obs_clr_n = 0; obs_en_n = 0; obs_en_first = -1; obs_en_last = -1;
        obs_latch_n = 0; obs_latch_cyc = -1; obs_mv_n = 0;
        obs_rchg_n = 0; obs_rchg_cyc = -1;
        obs_hf0 = highfreq; obs_hf_stable = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == mh_cyc) man_high = ~man_high;
            if (cnt_clr === 1'b1) obs_clr_n++;
            if (cnt_en === 1'b1) begin
                obs_en_n++;
                if (obs_en_first < 0) obs_en_first = c;
                obs_en_last = c;
            end
            if (latch_en === 1'b1) begin obs_latch_n++; obs_latch_cyc = c; end
            if (meas_valid === 1'b1) obs_mv_n++;
            if (range_chg === 1'b1) begin obs_rchg_n++; obs_rchg_cyc = c; end
            if (highfreq !== obs_hf0) obs_hf_stable = 1'b0;
            @(negedge sysclk);
        end
        obs_next_clr = cnt_clr;
        obs_hf_next  = highfreq;
        obs_ovf_flag = ovf_flag;
    endtask

    task automatic test_reset;
        reset = 1'b1; auto_en = 1'b0; man_high = 1'b0;
        ovf = 1'b0; bcd_th = 4'd3; bcd_hun = 4'd4;
        repeat (3) @(negedge sysclk);
        n_checks++;
        if ({cnt_clr, cnt_en, latch_en, meas_valid, range_chg, ovf_flag, highfreq} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {cnt_clr, cnt_en, latch_en, meas_valid, range_chg, ovf_flag, highfreq});
        end
        reset = 1'b0;
        @(negedge sysclk);
        n_checks++;
        if (cnt_clr !== 1'b1 || cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL first_clear: clr=%b en=%b, required clr=1 en=0", cnt_clr, cnt_en);
        end
    endtask

    task automatic test_manual_basic;
        for (int w = 0; w < 2; w++) begin
            run_window(1'b0, 4'd3, 4'd4, -1);
            n_checks++;
            if (obs_clr_n !== 1 || obs_en_n !== 10 || obs_en_first !== 1 || obs_en_last !== 10) begin
                n_fail++;
                $display("FAIL gate_timing w%0d: clr_n=%0d en_n=%0d first=%0d last=%0d, required 1/10/1/10",
                         w, obs_clr_n, obs_en_n, obs_en_first, obs_en_last);
            end
            n_checks++;
            if (obs_latch_n !== 1 || obs_latch_cyc !== 13 || obs_mv_n !== 1 || obs_rchg_n !== 0) begin
                n_fail++;
                $display("FAIL manual_latch w%0d: latch_n=%0d cyc=%0d mv_n=%0d rchg_n=%0d, required 1/13/1/0",
                         w, obs_latch_n, obs_latch_cyc, obs_mv_n, obs_rchg_n);
            end
            n_checks++;
            if (obs_next_clr !== 1'b1 || obs_hf_next !== 1'b0 || obs_ovf_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_period w%0d: clr@14=%b hf=%b ovf_flag=%b, required 1/0/0",
                         w, obs_next_clr, obs_hf_next, obs_ovf_flag);
            end
        end
    endtask

    task automatic test_auto_up;
        auto_en = 1'b1;
        run_window(1'b1, 4'd0, 4'd0, -1);
        n_checks++;
        if (obs_rchg_n !== 1 || obs_rchg_cyc !== 13 || obs_latch_n !== 0 || obs_mv_n !== 0) begin
            n_fail++;
            $display("FAIL auto_up_discard: rchg_n=%0d cyc=%0d latch_n=%0d mv_n=%0d, required 1/13/0/0",
                     obs_rchg_n, obs_rchg_cyc, obs_latch_n, obs_mv_n);
        end
        n_checks++;
        if (obs_hf0 !== 1'b0 || obs_hf_stable !== 1'b1 || obs_hf_next !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_up_range: hf=%b stable=%b hf@14=%b, required 0/1/1",
                     obs_hf0, obs_hf_stable, obs_hf_next);
        end
        run_window(1'b0, 4'd2, 4'd0, -1);
        n_checks++;
        if (obs_latch_cyc !== 13 || obs_rchg_n !== 0 || obs_ovf_flag !== 1'b0 || obs_hf_next !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_high_latch: latch_cyc=%0d rchg_n=%0d ovf_flag=%b hf=%b, required 13/0/0/1",
                     obs_latch_cyc, obs_rchg_n, obs_ovf_flag, obs_hf_next);
        end
    endtask

    task automatic test_auto_down;
        run_window(1'b0, 4'd0, 4'd1, -1);
        n_checks++;
        if (obs_latch_cyc !== 13 || obs_rchg_n !== 0 || obs_hf_next !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_stay_high: latch_cyc=%0d rchg_n=%0d hf=%b, required 13/0/1",
                     obs_latch_cyc, obs_rchg_n, obs_hf_next);
        end
        run_window(1'b0, 4'd0, 4'd0, -1);
        n_checks++;
        if (obs_rchg_cyc !== 13 || obs_latch_n !== 0 || obs_hf_stable !== 1'b1 || obs_hf_next !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_down: rchg_cyc=%0d latch_n=%0d stable=%b hf=%b, required 13/0/1/0",
                     obs_rchg_cyc, obs_latch_n, obs_hf_stable, obs_hf_next);
        end
    endtask

    task automatic test_high_overrange;
        // Return to the high range first; ovf in a discarded window must not
        // reach ovf_flag.
        run_window(1'b1, 4'd9, 4'd9, -1);
        n_checks++;
        if (obs_rchg_n !== 1 || obs_hf_next !== 1'b1 || obs_ovf_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reup: rchg_n=%0d hf=%b ovf_flag=%b, required 1/1/0",
                     obs_rchg_n, obs_hf_next, obs_ovf_flag);
        end
        run_window(1'b1, 4'd9, 4'd9, -1);
        n_checks++;
        if (obs_latch_cyc !== 13 || obs_rchg_n !== 0 || obs_ovf_flag !== 1'b1 || obs_hf_next !== 1'b1) begin
            n_fail++;
            $display("FAIL high_ovf_latch: latch_cyc=%0d rchg_n=%0d ovf_flag=%b hf=%b, required 13/0/1/1",
                     obs_latch_cyc, obs_rchg_n, obs_ovf_flag, obs_hf_next);
        end
        run_window(1'b0, 4'd5, 4'd0, -1);
        n_checks++;
        if (obs_latch_cyc !== 13 || obs_ovf_flag !== 1'b0 || obs_hf_next !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag_clear: latch_cyc=%0d ovf_flag=%b hf=%b, required 13/0/1",
                     obs_latch_cyc, obs_ovf_flag, obs_hf_next);
        end
    endtask

    task automatic test_manual_toggle;
        auto_en = 1'b0; man_high = 1'b1;
        run_window(1'b0, 4'd4, 4'd0, 5);      // man_high -> 0 mid-GATE
        n_checks++;
        if (obs_hf0 !== 1'b1 || obs_hf_stable !== 1'b1 || obs_latch_cyc !== 13 ||
            obs_rchg_n !== 0 || obs_hf_next !== 1'b0) begin
            n_fail++;
            $display("FAIL man_toggle_down: hf=%b stable=%b latch_cyc=%0d rchg_n=%0d hf@14=%b, required 1/1/13/0/0",
                     obs_hf0, obs_hf_stable, obs_latch_cyc, obs_rchg_n, obs_hf_next);
        end
        run_window(1'b1, 4'd0, 4'd0, 3);      // man_high -> 1; ovf must still latch
        n_checks++;
        if (obs_hf0 !== 1'b0 || obs_hf_stable !== 1'b1 || obs_latch_cyc !== 13 ||
            obs_rchg_n !== 0 || obs_hf_next !== 1'b1 || obs_ovf_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL man_toggle_up: hf=%b stable=%b latch_cyc=%0d rchg_n=%0d hf@14=%b ovf_flag=%b, required 0/1/13/0/1/1",
                     obs_hf0, obs_hf_stable, obs_latch_cyc, obs_rchg_n, obs_hf_next, obs_ovf_flag);
        end
    endtask

    task automatic test_reset_mid_gate;
        int bad;
        ovf = 1'b0; bcd_th = 4'd3; bcd_hun = 4'd4;
        repeat (5) @(negedge sysclk);
        n_checks++;
        if (cnt_en !== 1'b1 || highfreq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_gate: en=%b hf=%b, required 1/1", cnt_en, highfreq);
        end
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            if ({cnt_en, cnt_clr, latch_en, range_chg, meas_valid, highfreq, ovf_flag} !== 7'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: %0d cycles with active outputs, required 0", bad);
        end
        reset = 1'b0;
        @(negedge sysclk);
        n_checks++;
        if (cnt_clr !== 1'b1 || highfreq !== 1'b0 || latch_en !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_clear: clr=%b hf=%b latch=%b, required 1/0/0",
                     cnt_clr, highfreq, latch_en);
        end
        run_window(1'b0, 4'd3, 4'd4, -1);
        n_checks++;
        if (obs_en_n !== 10 || obs_latch_cyc !== 13 || obs_hf_stable !== 1'b1 || obs_hf_next !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_window: en_n=%0d latch_cyc=%0d stable=%b hf=%b, required 10/13/1/1",
                     obs_en_n, obs_latch_cyc, obs_hf_stable, obs_hf_next);
        end
    endtask

    initial begin
        test_reset;
        test_manual_basic;
        test_auto_up;
        test_auto_down;
        test_high_overrange;
        test_manual_toggle;
        test_reset_mid_gate;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_seq_ctrl.md
GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, gate window length in sysclk cycles (1 s at 100 MHz); legal range 2..2^27-1.
REQ-002 Parameter SETTLE_CYCLES, default 4, dead time after gate closes before decision; legal range 1..255.
REQ-003 sysclk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 auto_en  input  1  1 = automatic range selection, 0 = manual range.
REQ-006 man_high  input  1  manual range select (1 = high range, /10 prescaled input); used only when auto_en=0.
REQ-007 ovf  input  1  sticky counter overflow (count passed 9999) from BCD counter; cleared by cnt_clr.
REQ-008 bcd_th  input  4  thousands digit of running count.
REQ-009 bcd_hun  input  4  hundreds digit of running count.
REQ-010 cnt_clr  output  1  counter clear, one-cycle pulse.
REQ-011 cnt_en  output  1  counter enable (gate open).
REQ-012 latch_en  output  1  display latch load, one-cycle pulse.
REQ-013 highfreq  output  1  current range; drives prescaler mux and decimal-point indicator.
REQ-014 meas_valid  output  1  one-cycle pulse, coincident with latch_en.
REQ-015 range_chg  output  1  one-cycle pulse when auto-ranging switches range and discards the window.
REQ-016 ovf_flag  output  1  registered over-range indicator for the displayed value.

Function
REQ-017 FSM states CLEAR, GATE, HOLD, DECIDE; all outputs registered.
REQ-018 CLEAR: exactly 1 cycle, cnt_clr=1, cnt_en=0; next state GATE.
REQ-019 GATE: cnt_en=1 for exactly GATE_CYCLES consecutive cycles, tracked by an internal down-counter; next state HOLD.
REQ-020 HOLD: cnt_en=0 for exactly SETTLE_CYCLES cycles; next state DECIDE.
REQ-021 DECIDE: exactly 1 cycle; ovf, bcd_th and bcd_hun sampled only in this cycle; next state always CLEAR.
REQ-022 Measurement period is 2+GATE_CYCLES+SETTLE_CYCLES cycles; it SHALL repeat continuously with no idle state.
REQ-023 Auto, low range (auto_en=1, highfreq=0), ovf=1 in DECIDE: highfreq<=1, range_chg=1, latch_en=0, meas_valid=0.
REQ-024 Auto, high range (auto_en=1, highfreq=1), ovf=0 and bcd_th=0 and bcd_hun=0 in DECIDE (count <100): highfreq<=0, range_chg=1, no latch.
REQ-025 All other DECIDE cases: latch_en=1, meas_valid=1, ovf_flag<=ovf, highfreq unchanged.
REQ-026 High range with ovf=1 SHALL latch with ovf_flag<=1; there is no higher range.
REQ-027 Manual mode: at each DECIDE, highfreq<=man_high; always latch per REQ-025; range_chg never asserted.
REQ-028 If in manual mode man_high differs from highfreq at DECIDE, the window is still latched, range_chg=0, and the new range applies from the following CLEAR.
REQ-029 auto_en and man_high changes outside DECIDE SHALL NOT affect the current window; highfreq SHALL change only on the DECIDE-to-CLEAR edge.
REQ-030 cnt_clr, cnt_en, latch_en SHALL be mutually exclusive in every cycle.
REQ-031 Hysteresis: switch up at count >9999 in low range, switch down at count <100 in high range (<1 kHz); no oscillation for any steady input in 1 kHz..9.999 kHz.

Reset
REQ-032 While reset=1: state<=CLEAR, gate/settle counters cleared, cnt_en=0, cnt_clr=0, latch_en=0, meas_valid=0, range_chg=0, ovf_flag=0, highfreq=0.
REQ-033 First cycle after reset deasserts: cnt_clr=1 (CLEAR state).
REQ-034 Reset asserted in any state, including mid-GATE, SHALL abort the window without latch_en or range_chg pulse.

Verification (GATE_CYCLES=10, SETTLE_CYCLES=2, period 14)
REQ-035 Reset release, auto_en=0, man_high=0, ovf=0, bcd=3/4 -> cnt_clr at cycle 0, cnt_en cycles 1-10, latch_en+meas_valid at cycle 13, repeating every 14 cycles.
REQ-036 auto_en=1, highfreq=0, ovf=1 at DECIDE -> range_chg=1, no latch_en, highfreq=1 from next CLEAR; next window with ovf=0, bcd_th=2 -> latch_en=1, ovf_flag=0.
REQ-037 auto_en=1, highfreq=1, ovf=0, bcd_th=0, bcd_hun=0 at DECIDE -> range_chg=1, highfreq=0; with bcd_hun=1 instead -> latch, highfreq stays 1.
REQ-038 auto_en=1, highfreq=1, ovf=1 -> latch_en=1, ovf_flag=1, highfreq stays 1; next window ovf=0, bcd_th=5 -> ovf_flag=0.
REQ-039 reset pulsed at cycle 5 of GATE -> cnt_en low during reset, no latch_en/range_chg, cnt_clr on first post-reset cycle, highfreq=0.
REQ-040 man_high toggled mid-GATE in manual mode -> highfreq unchanged until DECIDE-to-CLEAR edge; mutual exclusivity of cnt_clr/cnt_en/latch_en asserted every cycle.
